// File: rtl/muldiv_iter_unit_if.sv
// muldiv_iter_unit_if: request/flush/completion bundle for the shared mul/div unit.
// master = execute/writeback side, slave = the unit itself.
interface muldiv_iter_unit_if #(
  parameter int XLEN       = 32,
  parameter int HART_ID_W  = 2,
  parameter int REG_ADDR_W = 5
);
  logic                  muldiv_req_valid;
  logic [2:0]            muldiv_op;
  logic [XLEN-1:0]       muldiv_a;
  logic [XLEN-1:0]       muldiv_b;
  logic [HART_ID_W-1:0]  muldiv_hart_id;
  logic [REG_ADDR_W-1:0] muldiv_rd;
  logic                  muldiv_flush_valid;
  logic [HART_ID_W-1:0]  muldiv_flush_hart_id;
  logic                  muldiv_busy;
  logic                  muldiv_done;
  logic [XLEN-1:0]       muldiv_result;
  logic [HART_ID_W-1:0]  muldiv_done_hart_id;
  logic [REG_ADDR_W-1:0] muldiv_done_rd;

  modport master (
    output muldiv_req_valid, muldiv_op, muldiv_a, muldiv_b,
    output muldiv_hart_id, muldiv_rd,
    output muldiv_flush_valid, muldiv_flush_hart_id,
    input  muldiv_busy, muldiv_done, muldiv_result,
    input  muldiv_done_hart_id, muldiv_done_rd
  );

  modport slave (
    input  muldiv_req_valid, muldiv_op, muldiv_a, muldiv_b,
    input  muldiv_hart_id, muldiv_rd,
    input  muldiv_flush_valid, muldiv_flush_hart_id,
    output muldiv_busy, muldiv_done, muldiv_result,
    output muldiv_done_hart_id, muldiv_done_rd
  );
endinterface

// File: rtl/muldiv_iter_unit.sv
// muldiv_iter_unit: shared radix-2 RV32M/RV64M mul/div with per-hart flush.
// Define MULDIV_EARLY_OUT_EN to let trivial operands skip the iteration loop.
module muldiv_iter_unit #(
  parameter int XLEN       = 32,
  parameter int HART_ID_W  = 2,
  parameter int REG_ADDR_W = 5
) (
  input logic               clk,
  input logic               rst,
  muldiv_iter_unit_if.slave bus
);
  localparam int CW = $clog2(XLEN + 1);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [2:0]            op_q, op_d;
  logic [XLEN-1:0]       a_q, a_d;
  logic [XLEN-1:0]       hi_q, hi_d;
  logic [XLEN-1:0]       lo_q, lo_d;
  logic [XLEN-1:0]       dvs_q, dvs_d;
  logic                  neg_q, neg_d;
  logic                  dz_q, dz_d;
  logic                  ovf_q, ovf_d;
  logic                  mz_q, mz_d;
  logic [HART_ID_W-1:0]  hart_q, hart_d;
  logic [REG_ADDR_W-1:0] rd_q, rd_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic [XLEN-1:0]       result_q, result_d;
  logic [HART_ID_W-1:0]  done_hart_q, done_hart_d;
  logic [REG_ADDR_W-1:0] done_rd_q, done_rd_d;

  logic                  a_sgn, b_sgn, sa, sb;
  logic                  req_div, req_dz, req_ovf, req_mz;
  logic                  accept, flush_hit, early;
  logic [XLEN-1:0]       abs_a, abs_b;
  logic [XLEN:0]         sum_mul, rem_sh;
  logic [XLEN-1:0]       rem_sub;
  logic                  rem_ge;
  logic [2*XLEN-1:0]     prod, prod_f;
  logic [XLEN-1:0]       quo_f, rem_f, res_f;

  always_comb begin
    a_sgn = 1'b0;
    b_sgn = 1'b0;
    unique case (1'b1)
      bus.muldiv_op == 3'd1,
      bus.muldiv_op == 3'd4,
      bus.muldiv_op == 3'd6: begin
        a_sgn = 1'b1;
        b_sgn = 1'b1;
      end
      bus.muldiv_op == 3'd2: a_sgn = 1'b1;
      default: ;
    endcase
  end

  assign sa      = a_sgn & bus.muldiv_a[XLEN-1];
  assign sb      = b_sgn & bus.muldiv_b[XLEN-1];
  assign abs_a   = sa ? -bus.muldiv_a : bus.muldiv_a;
  assign abs_b   = sb ? -bus.muldiv_b : bus.muldiv_b;
  assign req_div = bus.muldiv_op[2];
  assign req_dz  = req_div && (bus.muldiv_b == '0);
  assign req_ovf = req_div && !bus.muldiv_op[0]
                && (bus.muldiv_a == MIN_NEG)
                && (bus.muldiv_b == '1);
  assign req_mz  = !req_div
                && ((bus.muldiv_a == '0) || (bus.muldiv_b == '0));

`ifdef MULDIV_EARLY_OUT_EN
  assign early = req_dz | req_ovf | req_mz;
`else
  assign early = 1'b0;
`endif

  // A same-hart flush in the request cycle drops the request.
  assign accept = ((state_q == IDLE) || (state_q == DONE))
               && bus.muldiv_req_valid
               && !(bus.muldiv_flush_valid
                    && (bus.muldiv_flush_hart_id == bus.muldiv_hart_id));

  assign flush_hit = bus.muldiv_flush_valid
                  && (bus.muldiv_flush_hart_id == hart_q);

  // One iteration: shift-add for mul, restoring step for div.
  assign sum_mul = {1'b0, hi_q} + {1'b0, (lo_q[0] ? dvs_q : '0)};
  assign rem_sh  = {hi_q, lo_q[XLEN-1]};
  assign rem_ge  = rem_sh >= {1'b0, dvs_q};
  assign rem_sub = rem_sh[XLEN-1:0] - dvs_q;

  assign prod   = {hi_q, lo_q};
  assign prod_f = neg_q ? -prod : prod;
  assign quo_f  = neg_q ? -lo_q : lo_q;
  assign rem_f  = neg_q ? -hi_q : hi_q;

  always_comb begin
    if (dz_q)
      res_f = op_q[1] ? a_q : '1;
    else if (ovf_q)
      res_f = op_q[1] ? '0 : a_q;
    else if (mz_q)
      res_f = '0;
    else if (!op_q[2] && (op_q[1:0] == 2'd0))
      res_f = prod_f[XLEN-1:0];
    else if (!op_q[2])
      res_f = prod_f[2*XLEN-1:XLEN];
    else if (op_q[1])
      res_f = rem_f;
    else
      res_f = quo_f;
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    op_d        = op_q;
    a_d         = a_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    dvs_d       = dvs_q;
    neg_d       = neg_q;
    dz_d        = dz_q;
    ovf_d       = ovf_q;
    mz_d        = mz_q;
    hart_d      = hart_q;
    rd_d        = rd_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    result_d    = result_q;
    done_hart_d = done_hart_q;
    done_rd_d   = done_rd_q;
    unique case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        if (accept) begin
          state_d = early ? FIX : CALC;
          busy_d  = 1'b1;
          cnt_d   = CW'(XLEN);
          op_d    = bus.muldiv_op;
          a_d     = bus.muldiv_a;
          hart_d  = bus.muldiv_hart_id;
          rd_d    = bus.muldiv_rd;
          hi_d    = '0;
          lo_d    = req_div ? abs_a : abs_b;
          dvs_d   = req_div ? abs_b : abs_a;
          neg_d   = (req_div && bus.muldiv_op[1]) ? sa : (sa ^ sb);
          dz_d    = req_dz;
          ovf_d   = req_ovf;
          mz_d    = req_mz;
        end
      end
      CALC: begin
        if (flush_hit) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end else begin
          cnt_d = cnt_q - CW'(1);
          if (op_q[2]) begin
            hi_d = rem_ge ? rem_sub : rem_sh[XLEN-1:0];
            lo_d = {lo_q[XLEN-2:0], rem_ge};
          end else begin
            hi_d = sum_mul[XLEN:1];
            lo_d = {sum_mul[0], lo_q[XLEN-1:1]};
          end
          if (cnt_q == CW'(1))
            state_d = FIX;
        end
      end
      FIX: begin
        busy_d = 1'b0;
        if (flush_hit) begin
          state_d = IDLE;
        end else begin
          state_d     = DONE;
          done_d      = 1'b1;
          result_d    = res_f;
          done_hart_d = hart_q;
          done_rd_d   = rd_q;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      op_q        <= '0;
      a_q         <= '0;
      hi_q        <= '0;
      lo_q        <= '0;
      dvs_q       <= '0;
      neg_q       <= 1'b0;
      dz_q        <= 1'b0;
      ovf_q       <= 1'b0;
      mz_q        <= 1'b0;
      hart_q      <= '0;
      rd_q        <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      result_q    <= '0;
      done_hart_q <= '0;
      done_rd_q   <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      op_q        <= op_d;
      a_q         <= a_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
      dvs_q       <= dvs_d;
      neg_q       <= neg_d;
      dz_q        <= dz_d;
      ovf_q       <= ovf_d;
      mz_q        <= mz_d;
      hart_q      <= hart_d;
      rd_q        <= rd_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      result_q    <= result_d;
      done_hart_q <= done_hart_d;
      done_rd_q   <= done_rd_d;
    end
  end

  assign bus.muldiv_busy         = busy_q;
  assign bus.muldiv_done         = done_q;
  assign bus.muldiv_result       = result_q;
  assign bus.muldiv_done_hart_id = done_hart_q;
  assign bus.muldiv_done_rd      = done_rd_q;
endmodule

// File: tb/tb_muldiv_iter_unit.sv
// tb_muldiv_iter_unit: directed and random stimulus against an arithmetic
// reference model of the RV32M mul/div unit.
module tb_muldiv_iter_unit;
  localparam int XLEN = 32;
  localparam int LAT  = XLEN + 2;

  logic clk;
  logic rst;

  muldiv_iter_unit_if #(.XLEN(32), .HART_ID_W(2), .REG_ADDR_W(5)) bus ();

  muldiv_iter_unit #(.XLEN(32), .HART_ID_W(2), .REG_ADDR_W(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  task automatic check_eq(input string name, input logic [63:0] act,
                          input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_res(input logic [2:0] op,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
    longint          sa, sb, q;
    longint unsigned ua, ub;
    logic [63:0]     p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = 64'(a);
    ub = 64'(b);
    p  = '0;
    case (op)
      3'd0: begin p = ua * ub;            return p[31:0];  end
      3'd1: begin p = sa * sb;            return p[63:32]; end
      3'd2: begin p = sa * longint'(ub);  return p[63:32]; end
      3'd3: begin p = ua * ub;            return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        q = sa / sb;
        return q[31:0];
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        q = sa % sb;
        return q[31:0];
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int lat_of(input logic [2:0] op, input logic [31:0] a,
                                input logic [31:0] b);
    bit trivial;
    trivial = op[2] ? ((b == 0) ||
                       (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))
                    : ((a == 0) || (b == 0));
`ifdef MULDIV_EARLY_OUT_EN
    return trivial ? 2 : LAT;
`else
    return trivial ? LAT : LAT;
`endif
  endfunction

  // Reference model: at most one op in flight; cycle count since reset.
  bit          m_pend = 1'b0;
  int          m_cyc  = 0;
  int          m_due  = 0;
  logic [31:0] m_res  = '0;
  logic [1:0]  m_hart = '0;
  logic [4:0]  m_rd   = '0;
  logic        eb, ed;

  assign eb = m_pend && (m_cyc < m_due);
  assign ed = m_pend && (m_cyc == m_due);

  always @(negedge clk) begin
    if (chk_en) begin
      check_eq("busy", bus.muldiv_busy, eb);
      check_eq("done", bus.muldiv_done, ed);
      if (ed) begin
        check_eq("result", bus.muldiv_result, m_res);
        check_eq("done_hart", bus.muldiv_done_hart_id, m_hart);
        check_eq("done_rd", bus.muldiv_done_rd, m_rd);
      end
    end
    if (rst) begin
      m_pend <= 1'b0;
    end else if (eb && bus.muldiv_flush_valid
                 && bus.muldiv_flush_hart_id == m_hart) begin
      m_pend <= 1'b0;
    end else if (!eb && bus.muldiv_req_valid
                 && !(bus.muldiv_flush_valid
                      && bus.muldiv_flush_hart_id == bus.muldiv_hart_id)) begin
      m_pend <= 1'b1;
      m_due  <= m_cyc + lat_of(bus.muldiv_op, bus.muldiv_a, bus.muldiv_b);
      m_res  <= ref_res(bus.muldiv_op, bus.muldiv_a, bus.muldiv_b);
      m_hart <= bus.muldiv_hart_id;
      m_rd   <= bus.muldiv_rd;
    end else if (ed) begin
      m_pend <= 1'b0;
    end
    m_cyc <= m_cyc + 1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [1:0] h,
                       input logic [4:0] rd);
    bus.muldiv_op        = op;
    bus.muldiv_a         = a;
    bus.muldiv_b         = b;
    bus.muldiv_hart_id   = h;
    bus.muldiv_rd        = rd;
    bus.muldiv_req_valid = 1'b1;
    step();
    bus.muldiv_req_valid = 1'b0;
  endtask

  task automatic wait_done(input int start, input int limit,
                           output int lat, output bit seen);
    lat  = start;
    seen = 1'b0;
    while (!seen && lat < limit) begin
      @(negedge clk);
      if (bus.muldiv_done) seen = 1'b1;
      else begin
        step();
        lat++;
      end
    end
  endtask

  task automatic run_dir(input string name, input logic [2:0] op,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [1:0] h, input logic [4:0] rd,
                         input logic [31:0] exp, input bit trivial);
    int lat, lat_exp;
    bit seen;
    lat_exp = LAT;
`ifdef MULDIV_EARLY_OUT_EN
    if (trivial) lat_exp = 2;
`endif
    check_eq({name, "_model"}, ref_res(op, a, b), exp);
    issue(op, a, b, h, rd);
    wait_done(1, 60, lat, seen);
    check_eq({name, "_seen"}, seen, 1);
    check_eq({name, "_lat"}, lat, lat_exp);
    check_eq({name, "_res"}, bus.muldiv_result, exp);
    check_eq({name, "_rd"}, bus.muldiv_done_rd, rd);
    check_eq({name, "_hart"}, bus.muldiv_done_hart_id, h);
    step();
    @(negedge clk);
    check_eq({name, "_pulse"}, bus.muldiv_done, 0);
    step();
  endtask

  function automatic logic [31:0] rand_opnd();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int  lat;
    bit  seen;
    rst = 1'b1;
    bus.muldiv_req_valid     = 1'b0;
    bus.muldiv_op            = '0;
    bus.muldiv_a             = '0;
    bus.muldiv_b             = '0;
    bus.muldiv_hart_id       = '0;
    bus.muldiv_rd            = '0;
    bus.muldiv_flush_valid   = 1'b0;
    bus.muldiv_flush_hart_id = '0;
    repeat (3) step();
    rst = 1'b0;
    chk_en = 1'b1;
    @(negedge clk);
    check_eq("rst_result", bus.muldiv_result, 0);
    check_eq("rst_hart", bus.muldiv_done_hart_id, 0);
    check_eq("rst_rd", bus.muldiv_done_rd, 0);
    step();

    run_dir("mul",    3'd0, 32'd7,         32'hFFFF_FFFD, 2'd2, 5'd5,  32'hFFFF_FFEB, 0);
    run_dir("mulh",   3'd1, 32'h8000_0000, 32'h8000_0000, 2'd1, 5'd6,  32'h4000_0000, 0);
    run_dir("mulhsu", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'd0, 5'd7,  32'hFFFF_FFFF, 0);
    run_dir("mulhu",  3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'd3, 5'd8,  32'hFFFF_FFFE, 0);
    run_dir("div",    3'd4, 32'hFFFF_FFF9, 32'd2,         2'd1, 5'd9,  32'hFFFF_FFFD, 0);
    run_dir("rem",    3'd6, 32'hFFFF_FFF9, 32'd2,         2'd1, 5'd10, 32'hFFFF_FFFF, 0);
    run_dir("divu",   3'd5, 32'd100,       32'd7,         2'd0, 5'd11, 32'd14,        0);
    run_dir("remu",   3'd7, 32'd100,       32'd7,         2'd0, 5'd12, 32'd2,         0);
    run_dir("div0",   3'd4, 32'd5,         32'd0,         2'd2, 5'd13, 32'hFFFF_FFFF, 1);
    run_dir("rem0",   3'd6, 32'd5,         32'd0,         2'd2, 5'd14, 32'd5,         1);
    run_dir("divovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 2'd3, 5'd15, 32'h8000_0000, 1);
    run_dir("removf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 2'd3, 5'd16, 32'd0,         1);
    run_dir("mulz",   3'd0, 32'd0,         32'h1234,      2'd0, 5'd17, 32'd0,         1);

    // Matching flush in cycle 10 cancels the op.
    issue(3'd4, 32'hFFFF_FFF9, 32'd2, 2'd1, 5'd3);
    repeat (9) step();
    bus.muldiv_flush_valid   = 1'b1;
    bus.muldiv_flush_hart_id = 2'd1;
    step();
    bus.muldiv_flush_valid = 1'b0;
    @(negedge clk);
    check_eq("flush_busy", bus.muldiv_busy, 0);
    step();
    wait_done(12, 50, lat, seen);
    check_eq("flush_nodone", seen, 0);
    step();

    // Non-matching flush leaves the op alone.
    issue(3'd4, 32'hFFFF_FFF9, 32'd2, 2'd1, 5'd3);
    repeat (9) step();
    bus.muldiv_flush_valid   = 1'b1;
    bus.muldiv_flush_hart_id = 2'd0;
    step();
    bus.muldiv_flush_valid = 1'b0;
    wait_done(11, 60, lat, seen);
    check_eq("nflush_lat", lat, LAT);
    check_eq("nflush_res", bus.muldiv_result, 32'hFFFF_FFFD);
    step();

    // Request on the DONE cycle is accepted.
    issue(3'd5, 32'd100, 32'd7, 2'd0, 5'd1);
    repeat (33) step();
    bus.muldiv_op        = 3'd7;
    bus.muldiv_a         = 32'd100;
    bus.muldiv_b         = 32'd7;
    bus.muldiv_hart_id   = 2'd2;
    bus.muldiv_rd        = 5'd2;
    bus.muldiv_req_valid = 1'b1;
    @(negedge clk);
    check_eq("b2b_done1", bus.muldiv_done, 1);
    check_eq("b2b_res1", bus.muldiv_result, 32'd14);
    step();
    bus.muldiv_req_valid = 1'b0;
    wait_done(1, 60, lat, seen);
    check_eq("b2b_lat2", lat, LAT);
    check_eq("b2b_res2", bus.muldiv_result, 32'd2);
    step();

    // Request while busy is ignored.
    issue(3'd5, 32'd100, 32'd7, 2'd0, 5'd1);
    repeat (4) step();
    issue(3'd0, 32'd3, 32'd3, 2'd1, 5'd9);
    wait_done(6, 60, lat, seen);
    check_eq("busy_ign_lat", lat, LAT);
    check_eq("busy_ign_res", bus.muldiv_result, 32'd14);
    check_eq("busy_ign_rd", bus.muldiv_done_rd, 5'd1);
    step();

    // Reset in cycle 15 aborts the op.
    issue(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'd0, 5'd4);
    repeat (14) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    check_eq("rst_mid_busy", bus.muldiv_busy, 0);
    check_eq("rst_mid_done", bus.muldiv_done, 0);
    step();
    wait_done(17, 60, lat, seen);
    check_eq("rst_mid_nodone", seen, 0);
    step();

    for (int i = 0; i < 5000; i++) begin
      bus.muldiv_req_valid     = ($urandom_range(0, 3) == 0);
      bus.muldiv_op            = 3'($urandom_range(0, 7));
      bus.muldiv_a             = rand_opnd();
      bus.muldiv_b             = rand_opnd();
      bus.muldiv_hart_id       = 2'($urandom_range(0, 3));
      bus.muldiv_rd            = 5'($urandom_range(0, 31));
      bus.muldiv_flush_valid   = ($urandom_range(0, 49) == 0);
      bus.muldiv_flush_hart_id = 2'($urandom_range(0, 3));
      step();
    end
    bus.muldiv_req_valid   = 1'b0;
    bus.muldiv_flush_valid = 1'b0;
    repeat (LAT + 4) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end
endmodule
